// File: rtl/clk_sched_pkg.sv
// Shared types and constants for the clock-enable scheduler.
// Provides the run/stop state encoding and the per-channel power-on divide value.
package clk_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } sched_state_e;

  localparam int DEF_NCH  = 4;
  localparam int DEF_CNTW = 16;

  // Channel i powers up dividing by 2^i, giving clk/2, /4, /8, ... on phase.
  function automatic logic [31:0] reset_div(input int idx);
    return 32'd1 << idx;
  endfunction

endpackage

// File: rtl/clk_en_chan.sv
// One scheduler channel: divide register, period counter, tick/phase flops and freeze logic.
// A channel counts while running, or while stopping with its phase still high.
module clk_en_chan
  import clk_sched_pkg::*;
#(
  parameter int              CNTW    = DEF_CNTW,
  parameter logic [CNTW-1:0] RST_DIV = CNTW'(1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  input  logic            stop_req,
  input  logic            load,
  input  logic [CNTW-1:0] load_div,
  output logic            boundary,
  output logic            frozen,
  output logic            tick,
  output logic            phase
);

  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [CNTW-1:0] div_q, div_d;
  logic            tick_q, tick_d;
  logic            phase_q, phase_d;
  logic            div_off;
  logic            active;

  always_comb begin
    div_off  = (div_q == '0);
    boundary = !div_off && (cnt_q == div_q - CNTW'(1));
    // Off channels count as frozen so a pending write to them lands at once.
    frozen   = div_off || (stop_req && !phase_q);
    active   = !div_off && (run || (stop_req && phase_q));

    div_d   = div_q;
    cnt_d   = '0;
    tick_d  = 1'b0;
    phase_d = 1'b0;

    if (active) begin
      cnt_d   = boundary ? '0 : cnt_q + CNTW'(1);
      tick_d  = boundary;
      phase_d = phase_q ^ boundary;
    end

    // A load at a boundary keeps that boundary's tick; only a zero divide kills it.
    if (load) begin
      div_d = load_div;
      cnt_d = '0;
      if (load_div == '0) begin
        tick_d  = 1'b0;
        phase_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      div_q   <= RST_DIV;
      tick_q  <= 1'b0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      tick_q  <= tick_d;
      phase_q <= phase_d;
    end
  end

  assign tick  = tick_q;
  assign phase = phase_q;

endmodule

// File: rtl/clk_en_scheduler.sv
// Clock-enable scheduler top: run/stop FSM, single-entry config slot and per-channel apply.
// All derived rates are tick strobes and phase levels in the clk domain.
module clk_en_scheduler
  import clk_sched_pkg::*;
#(
  parameter int NCH  = DEF_NCH,
  parameter int CNTW = DEF_CNTW,
  parameter int CHW  = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [CHW-1:0]  cfg_ch,
  input  logic [CNTW-1:0] cfg_div,
  output logic [NCH-1:0]  tick,
  output logic [NCH-1:0]  phase,
  output logic            busy
);

  sched_state_e    state_q, state_d;
  logic            pend_q, pend_d;
  logic [CHW-1:0]  pend_ch_q, pend_ch_d;
  logic [CNTW-1:0] pend_div_q, pend_div_d;

  logic [NCH-1:0]  boundary;
  logic [NCH-1:0]  frozen;
  logic [NCH-1:0]  load;
  logic            cfg_fire;
  logic            pend_bad;
  logic            run;
  logic            stop_req;

  assign run       = (state_q == RUN);
  assign stop_req  = (state_q == STOP);
  assign cfg_ready = !pend_q;
  assign cfg_fire  = cfg_valid && cfg_ready;
  assign pend_bad  = pend_q && (int'(pend_ch_q) >= NCH);
  assign busy      = (state_q != IDLE) || pend_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (enable) state_d = RUN;
      RUN:  if (!enable) state_d = STOP;
      STOP: begin
        if (enable) begin
          state_d = RUN;
        end else if (&frozen) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The slot frees when its channel takes the value or the target does not exist.
  always_comb begin
    pend_d     = pend_q;
    pend_ch_d  = pend_ch_q;
    pend_div_d = pend_div_q;
    if (pend_q && ((|load) || pend_bad)) begin
      pend_d = 1'b0;
    end
    if (cfg_fire) begin
      pend_d     = 1'b1;
      pend_ch_d  = cfg_ch;
      pend_div_d = cfg_div;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pend_q     <= 1'b0;
      pend_ch_q  <= '0;
      pend_div_q <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      pend_ch_q  <= pend_ch_d;
      pend_div_q <= pend_div_d;
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    assign load[gi] = pend_q && (pend_ch_q == CHW'(gi)) &&
                      (boundary[gi] || frozen[gi] || (state_q == IDLE));

    clk_en_chan #(
      .CNTW    (CNTW),
      .RST_DIV (CNTW'(reset_div(gi)))
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .run      (run),
      .stop_req (stop_req),
      .load     (load[gi]),
      .load_div (pend_div_q),
      .boundary (boundary[gi]),
      .frozen   (frozen[gi]),
      .tick     (tick[gi]),
      .phase    (phase[gi])
    );
  end

endmodule

// File: tb/tb_clk_en_scheduler.sv
// Directed bench for clk_en_scheduler: expectations are queued per cycle from a
// closed-form period model and compared one cycle at a time after each clock edge.
module tb_clk_en_scheduler;

  localparam int NCH  = 4;
  localparam int CNTW = 16;
  // A 3-bit select lets the bench address a channel number that does not exist.
  localparam int CHW  = 3;

  localparam int SEL_TICK  = 0;
  localparam int SEL_PHASE = 1;
  localparam int SEL_RDY   = 2;
  localparam int SEL_BUSY  = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            enable = 1'b0;
  logic            cfg_valid = 1'b0;
  logic            cfg_ready;
  logic [CHW-1:0]  cfg_ch = '0;
  logic [CNTW-1:0] cfg_div = '0;
  logic [NCH-1:0]  tick;
  logic [NCH-1:0]  phase;
  logic            busy;

  always #5 clk = ~clk;

  clk_en_scheduler #(
    .NCH  (NCH),
    .CNTW (CNTW),
    .CHW  (CHW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .tick      (tick),
    .phase     (phase),
    .busy      (busy)
  );

  typedef struct {
    int         cyc;
    int         sel;
    logic [7:0] mask;
    logic [7:0] val;
    int         scn;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   n_checks;
  int   n_errors;

  // Each channel's current counting epoch: started at cycle seg_s with phase seg_p.
  int   seg_s[NCH];
  int   seg_d[NCH];
  bit   seg_p[NCH];

  function automatic bit tick_at(input int i, input int c);
    int m;
    m = c - seg_s[i];
    if (seg_d[i] == 0 || m < 1) return 1'b0;
    return (m % seg_d[i]) == 0;
  endfunction

  function automatic bit phase_at(input int i, input int c);
    int m;
    m = c - seg_s[i];
    if (seg_d[i] == 0 || m < 0) return 1'b0;
    return seg_p[i] ^ (((m / seg_d[i]) % 2) == 1);
  endfunction

  function automatic string sel_name(input int sel);
    case (sel)
      SEL_TICK:  return "tick";
      SEL_PHASE: return "phase";
      SEL_RDY:   return "cfg_ready";
      default:   return "busy";
    endcase
  endfunction

  function automatic logic [7:0] observe(input int sel);
    case (sel)
      SEL_TICK:  return 8'(tick);
      SEL_PHASE: return 8'(phase);
      SEL_RDY:   return 8'(cfg_ready);
      default:   return 8'(busy);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic push(input int c, input int sel, input logic [7:0] mask,
                      input logic [7:0] val, input int scn);
    exp_t e;
    e.cyc  = c;
    e.sel  = sel;
    e.mask = mask;
    e.val  = val;
    e.scn  = scn;
    sb.push_back(e);
  endtask

  task automatic push_ch(input int i, input int c0, input int c1, input int scn);
    for (int c = c0; c <= c1; c++) begin
      push(c, SEL_TICK,  8'(1 << i), 8'(int'(tick_at(i, c)) << i), scn);
      push(c, SEL_PHASE, 8'(1 << i), 8'(int'(phase_at(i, c)) << i), scn);
    end
  endtask

  task automatic push_zero(input int i, input int c0, input int c1, input int scn);
    for (int c = c0; c <= c1; c++) begin
      push(c, SEL_TICK,  8'(1 << i), 8'h00, scn);
      push(c, SEL_PHASE, 8'(1 << i), 8'h00, scn);
    end
  endtask

  task automatic drain();
    int j;
    j = 0;
    while (j < sb.size()) begin
      if (sb[j].cyc < cyc) begin
        n_checks++;
        n_errors++;
        $error("FAIL s%0d_%s: expectation for cycle %0d never sampled (now %0d)",
               sb[j].scn, sel_name(sb[j].sel), sb[j].cyc, cyc);
        sb.delete(j);
      end else if (sb[j].cyc == cyc) begin
        chk($sformatf("s%0d_%s", sb[j].scn, sel_name(sb[j].sel)),
            observe(sb[j].sel) & sb[j].mask, sb[j].val & sb[j].mask);
        sb.delete(j);
      end else begin
        j++;
      end
    end
  endtask

  task automatic run_cycles(input int n);
    for (int s = 0; s < n; s++) begin
      @(posedge clk);
      #1;
      cyc++;
      drain();
    end
  endtask

  initial begin
    int k, t, a, e, f, last;
    int fe[NCH];
    bit found;

    n_checks = 0;
    n_errors = 0;
    cyc      = 0;

    // Reset values while reset is held.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tick",  8'(tick),      8'h00);
    chk("rst_phase", 8'(phase),     8'h00);
    chk("rst_ready", 8'(cfg_ready), 8'h01);
    chk("rst_busy",  8'(busy),      8'h00);
    reset = 1'b0;
    cyc   = 0;

    // Scenario 1: start with default divides 1, 2, 4, 8.
    enable = 1'b1;
    k = cyc + 1;
    for (int i = 0; i < NCH; i++) begin
      seg_s[i] = k;
      seg_d[i] = 1 << i;
      seg_p[i] = 1'b0;
      push_ch(i, k, k + 34, 1);
    end
    push(k, SEL_BUSY, 8'h01, 8'h01, 1);
    push(k, SEL_RDY,  8'h01, 8'h01, 1);
    run_cycles(35);

    // Scenario 2: channel 2 from 4 to 3, written one cycle into a period.
    for (int w = 0; w < 8 && (((cyc + 1 - k) % 4) != 1); w++) run_cycles(1);
    t = cyc + 1;
    cfg_valid = 1'b1;
    cfg_ch    = 3'd2;
    cfg_div   = 16'd3;
    a = t + 1;
    while (!tick_at(2, a)) a++;
    push_ch(2, t, a, 2);
    for (int c = t; c < a; c++) push(c, SEL_RDY, 8'h01, 8'h00, 2);
    push(a, SEL_RDY, 8'h01, 8'h01, 2);
    seg_p[2] = phase_at(2, a);
    seg_s[2] = a;
    seg_d[2] = 3;
    push_ch(2, a + 1, a + 13, 2);
    run_cycles(1);
    cfg_valid = 1'b0;
    run_cycles(a + 13 - cyc);

    // Scenario 4a: switch channel 1 off; it goes quiet at its next boundary.
    t = cyc + 1;
    cfg_valid = 1'b1;
    cfg_ch    = 3'd1;
    cfg_div   = 16'd0;
    a = t + 1;
    while (!tick_at(1, a)) a++;
    push_ch(1, t, a - 1, 4);
    for (int c = t; c < a; c++) push(c, SEL_RDY, 8'h01, 8'h00, 4);
    push(a, SEL_RDY, 8'h01, 8'h01, 4);
    seg_s[1] = a - 1;
    seg_d[1] = 0;
    seg_p[1] = 1'b0;
    push_ch(1, a, a + 6, 4);
    run_cycles(1);
    cfg_valid = 1'b0;
    run_cycles(a + 6 - cyc);

    // Scenario 4b: an off channel takes a new divide on the next edge.
    t = cyc + 1;
    cfg_valid = 1'b1;
    cfg_ch    = 3'd1;
    cfg_div   = 16'd5;
    push(t,     SEL_RDY, 8'h01, 8'h00, 5);
    push(t + 1, SEL_RDY, 8'h01, 8'h01, 5);
    seg_s[1] = t + 1;
    seg_d[1] = 5;
    seg_p[1] = 1'b0;
    push_ch(1, t, t + 21, 5);
    run_cycles(1);
    cfg_valid = 1'b0;
    run_cycles(t + 21 - cyc);

    // Scenario 3: drop enable with phase[3] high and its tick five cycles away.
    found = 1'b0;
    for (int w = 0; w < 40; w++) begin
      if (phase_at(3, cyc + 1) && tick_at(3, cyc + 6)) begin
        found = 1'b1;
        break;
      end
      run_cycles(1);
    end
    if (!found) begin
      n_errors++;
      $display("FAIL stop_window: no cycle with phase[3] high five cycles before its tick");
    end
    e = cyc + 1;
    enable = 1'b0;
    last = e;
    for (int i = 0; i < NCH; i++) begin
      if (phase_at(i, e)) begin
        f = e + 1;
        while (!tick_at(i, f)) f++;
        push_ch(i, e, f, 3);
        fe[i] = f;
      end else begin
        push_ch(i, e, e, 3);
        fe[i] = e;
      end
      if (fe[i] > last) last = fe[i];
    end
    for (int i = 0; i < NCH; i++) push_zero(i, fe[i] + 1, last + 3, 3);
    for (int c = e; c <= last; c++) push(c, SEL_BUSY, 8'h01, 8'h01, 3);
    for (int c = last + 1; c <= last + 3; c++) push(c, SEL_BUSY, 8'h01, 8'h00, 3);
    run_cycles(last + 3 - cyc);

    // Scenario 5: out-of-range channel, plus a second write while the slot is full.
    t = cyc + 1;
    cfg_valid = 1'b1;
    cfg_ch    = CHW'(NCH);
    cfg_div   = 16'd7;
    push(t,     SEL_RDY,  8'h01, 8'h00, 6);
    push(t,     SEL_BUSY, 8'h01, 8'h01, 6);
    push(t + 1, SEL_RDY,  8'h01, 8'h01, 6);
    push(t + 1, SEL_BUSY, 8'h01, 8'h00, 6);
    push(t + 2, SEL_RDY,  8'h01, 8'h01, 6);
    push(t + 2, SEL_BUSY, 8'h01, 8'h00, 6);
    run_cycles(1);
    cfg_ch  = 3'd0;
    cfg_div = 16'd9;
    run_cycles(1);
    cfg_valid = 1'b0;
    run_cycles(1);

    // Divides must still be 1, 5, 3, 8 after those writes.
    enable = 1'b1;
    k = cyc + 1;
    for (int i = 0; i < NCH; i++) begin
      seg_s[i] = k;
      seg_p[i] = 1'b0;
      push_ch(i, k, k + 24, 7);
    end
    run_cycles(25);

    // Scenario 6: asynchronous reset mid-run with a config pending on channel 3.
    t = cyc + 1;
    cfg_valid = 1'b1;
    cfg_ch    = 3'd3;
    cfg_div   = 16'd2;
    push(t, SEL_RDY,  8'h01, 8'h00, 8);
    push(t, SEL_BUSY, 8'h01, 8'h01, 8);
    run_cycles(1);
    cfg_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("rstmid_tick",  8'(tick),      8'h00);
    chk("rstmid_phase", 8'(phase),     8'h00);
    chk("rstmid_ready", 8'(cfg_ready), 8'h01);
    chk("rstmid_busy",  8'(busy),      8'h00);
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;

    // Divides are back at 1, 2, 4, 8 and the lost config has no effect.
    enable = 1'b1;
    k = cyc + 1;
    for (int i = 0; i < NCH; i++) begin
      seg_s[i] = k;
      seg_d[i] = 1 << i;
      seg_p[i] = 1'b0;
      push_ch(i, k, k + 17, 9);
    end
    push(k, SEL_RDY, 8'h01, 8'h01, 9);
    run_cycles(18);
    enable = 1'b0;

    while (sb.size() > 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL s%0d_%s: expectation for cycle %0d left unchecked",
             sb[0].scn, sel_name(sb[0].sel), sb[0].cyc);
      sb.delete(0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
